seq_shift_add_mult: RTL and testbench
=====================================

// Module: seq_shift_add_mult
// PURPOSE
//  Sequential unsigned shift-and-add multiplier; WIDTH x WIDTH -> 2*WIDTH product.
//  Consumes one partial-product addition per cycle through a WIDTH-bit ripple adder;
//  this block is the controller/datapath stage that drives that adder.
//  Valid/ready on both sides; one multiplication in flight at a time.
// PARAMETERS
//  WIDTH  4  operand width in bits (>=2); product is 2*WIDTH bits
// PORTS
//  clk       in   1        rising-edge clock
//  rst       in   1        synchronous reset, active-high
//  in_valid  in   1        operands present on in_A/in_B
//  in_ready  out  1        block idle, accepts operands (high iff state==IDLE)
//  in_A      in   WIDTH    multiplicand (unsigned)
//  in_B      in   WIDTH    multiplier (unsigned)
//  out_valid out  1        out_P holds a finished product
//  out_ready in   1        downstream consumes product
//  out_P     out  2*WIDTH  product in_A*in_B
// BEHAVIOUR
//  - One clock (clk); reset synchronous, active-high (rst). At rst edge: state=IDLE,
//    out_valid=0, out_P=0, count=0, in_ready=1 after that edge; inputs ignored while rst=1.
//  - FSM IDLE->RUN->DONE->IDLE.
//  - IDLE: accept on in_valid&&in_ready: MC<=in_A; P<={WIDTH'b0,in_B}; count<=0; ->RUN.
//  - RUN, each cycle: if P[0]: {c,s}=P[2W-1:W]+MC (adder, Cin=0); P<={c,s,P[W-1:1]};
//    else P<={1'b0,P[2W-1:1]}. count++; when count==WIDTH-1 -> DONE.
//  - Latency: out_valid rises exactly WIDTH+1 clock edges after the accepting edge.
//  - DONE: out_valid=1, out_P=P; out_P/out_valid stable while out_ready=0.
//    out_valid&&out_ready -> IDLE, out_valid=0 next cycle; in_ready rises same edge.
//  - in_ready=0 in RUN and DONE; in_valid there ignored, operands not sampled.
//  - out_P keeps last product after handshake until next product completes.
//  - Arithmetic: carry out of adder is bit 2W-1 of the shifted P; no overflow possible.
//  - rst mid-RUN or mid-DONE: operation abandoned, no out_valid pulse, all reset values.
// CONFIGURATION
//  MULT_ZERO_BYPASS_EN defined: at accept, if in_A==0 or in_B==0, go directly to DONE
//  with P=0; out_valid rises 1 edge after the accepting edge (RUN skipped).
//  Not defined: zero operands take the full WIDTH+1 latency; product still 0.
// STRUCTURE
//  - Package mult_pkg: state typedef (IDLE,RUN,DONE), default WIDTH constant,
//    counter width = $clog2(WIDTH).
//  - Sub-module ripple_adder_n (WIDTH-bit ripple adder of full-adder cells,
//    ports in_A,in_B,Cin,out_C,carry); instantiated once, Cin tied 0.
//  - Top holds FSM, count, MC and P registers, output register.
// TESTING (WIDTH=4 unless noted)
//  1 in_A=13,in_B=11, out_ready=1 -> out_P=143 (0x8F), out_valid 5 edges after accept.
//  2 in_A=15,in_B=15 -> out_P=225 (0xE1); carry into bit 7 exercised.
//  3 out_ready=0 for 10 cycles after out_valid -> out_P/out_valid held, in_ready=0;
//    then handshake -> IDLE, in_ready=1 next cycle.
//  4 in_valid pulsed during RUN with in_A=3,in_B=3 -> ignored; first product unchanged.
//  5 rst asserted 2 cycles into RUN -> out_valid=0,out_P=0,in_ready=1; next op 6*7=42.
//  6 in_A=0,in_B=9 -> out_P=0; latency 1 edge with MULT_ZERO_BYPASS_EN, 5 without.
//  Plus exhaustive 256-pair sweep vs. reference model, random out_ready backpressure.

Source files
------------

// File: rtl/seq_shift_add_mult_pkg.sv
// Shared types and constants for the sequential shift-and-add multiplier.
package mult_pkg;

    localparam int WIDTH_DEF = 4;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    // Step counter only needs to reach WIDTH-1; never let it collapse to zero bits.
    function automatic int cnt_w(input int w);
        return (w > 2) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/seq_shift_add_mult_if.sv
// Operand/product valid-ready bundle for seq_shift_add_mult.
interface seq_shift_add_mult_if
    import mult_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
);
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     in_A;
    logic [WIDTH-1:0]     in_B;
    logic                 out_valid;
    logic                 out_ready;
    logic [2*WIDTH-1:0]   out_P;

    modport master (
        output in_valid, in_A, in_B, out_ready,
        input  in_ready, out_valid, out_P
    );

    modport slave (
        input  in_valid, in_A, in_B, out_ready,
        output in_ready, out_valid, out_P
    );
endinterface

// File: rtl/seq_shift_add_mult_adder.sv
// WIDTH-bit ripple-carry adder built from a chain of full-adder cells.
module ripple_adder_n #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] in_A,
    input  logic [WIDTH-1:0] in_B,
    input  logic             Cin,
    output logic [WIDTH-1:0] out_C,
    output logic             carry
);
    logic [WIDTH:0] c;

    assign c[0] = Cin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_fa
        assign out_C[i] = in_A[i] ^ in_B[i] ^ c[i];
        assign c[i+1]   = (in_A[i] & in_B[i]) | (c[i] & (in_A[i] ^ in_B[i]));
    end

    assign carry = c[WIDTH];
endmodule

// File: rtl/seq_shift_add_mult.sv
// Sequential unsigned shift-and-add multiplier, one adder pass per cycle.
// Optional: MULT_ZERO_BYPASS_EN skips RUN when either operand is zero.
module seq_shift_add_mult
    import mult_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic               clk,
    input  logic               rst,
    seq_shift_add_mult_if.slave bus
);
    localparam int CW = cnt_w(WIDTH);

    state_t             state, state_nx;
    logic [CW-1:0]      count;
    logic [WIDTH-1:0]   mc;
    logic [2*WIDTH-1:0] p, p_shift, out_p;
    logic [WIDTH-1:0]   sum;
    logic               carry;
    logic               accept, last, zero_op;

    ripple_adder_n #(.WIDTH(WIDTH)) u_add (
        .in_A  (p[2*WIDTH-1:WIDTH]),
        .in_B  (mc),
        .Cin   (1'b0),
        .out_C (sum),
        .carry (carry)
    );

    // Adder carry lands in the top bit of the shifted accumulator.
    assign p_shift = p[0] ? {carry, sum, p[WIDTH-1:1]} : {1'b0, p[2*WIDTH-1:1]};

    assign accept = bus.in_valid && (state == IDLE);
    assign last   = (count == CW'(WIDTH-1));

`ifdef MULT_ZERO_BYPASS_EN
    assign zero_op = (bus.in_A == '0) || (bus.in_B == '0);
`else
    assign zero_op = 1'b0;
`endif

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (accept) state_nx = zero_op ? DONE : RUN;
            RUN:     if (last) state_nx = DONE;
            DONE:    if (bus.out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            count <= '0;
            mc    <= '0;
            p     <= '0;
            out_p <= '0;
        end else begin
            state <= state_nx;
            unique case (state)
                IDLE: if (accept) begin
                    mc    <= bus.in_A;
                    p     <= zero_op ? '0 : {{WIDTH{1'b0}}, bus.in_B};
                    count <= '0;
                    if (zero_op) out_p <= '0;
                end
                RUN: begin
                    p     <= p_shift;
                    count <= count + 1'b1;
                    if (last) out_p <= p_shift;
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.out_P     = out_p;
endmodule

// File: tb/tb_seq_shift_add_mult.sv
// Directed bench for seq_shift_add_mult (WIDTH=4) plus a full operand sweep.
module tb_seq_shift_add_mult;
    import mult_pkg::*;

    localparam int W = 4;
`ifdef MULT_ZERO_BYPASS_EN
    localparam int ZLAT = 1;
`else
    localparam int ZLAT = W + 1;
`endif

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    seq_shift_add_mult_if #(.WIDTH(W)) bus ();

    seq_shift_add_mult #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present operands, count edges (accept edge included) until out_valid.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic rdy,
                          output int lat, output logic [2*W-1:0] prod);
        bus.in_A      = a;
        bus.in_B      = b;
        bus.in_valid  = 1'b1;
        bus.out_ready = rdy;
        lat = 0;
        while (lat < 40) begin
            step();
            lat++;
            if (lat == 1) bus.in_valid = 1'b0;
            if (bus.out_valid) break;
        end
        bus.in_valid = 1'b0;
        prod = bus.out_P;
    endtask

    initial begin
        int lat;
        logic [2*W-1:0] prod;
        logic seen;

        rst           = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_A      = 4'd5;
        bus.in_B      = 4'd5;
        bus.out_ready = 1'b0;
        step();
        step();
        chk("rst_in_ready",  32'(bus.in_ready),  32'd1);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_P",     32'(bus.out_P),     32'd0);
        bus.in_valid = 1'b0;
        rst = 1'b0;
        step();

        // 1: basic product and latency
        run_op(4'd13, 4'd11, 1'b1, lat, prod);
        chk("t1_lat",  32'(lat),  32'd5);
        chk("t1_prod", 32'(prod), 32'h8F);
        step();
        chk("t1_idle", 32'(bus.in_ready), 32'd1);

        // 2: all-ones operands, carry into the top product bit
        run_op(4'd15, 4'd15, 1'b1, lat, prod);
        chk("t2_lat",  32'(lat),  32'd5);
        chk("t2_prod", 32'(prod), 32'hE1);
        step();

        // 3: downstream backpressure holds the result
        run_op(4'd9, 4'd7, 1'b0, lat, prod);
        chk("t3_prod", 32'(prod), 32'd63);
        for (int i = 0; i < 10; i++) begin
            step();
            chk("t3_hold_valid", 32'(bus.out_valid), 32'd1);
            chk("t3_hold_P",     32'(bus.out_P),     32'd63);
            chk("t3_hold_ready", 32'(bus.in_ready),  32'd0);
        end
        bus.out_ready = 1'b1;
        step();
        chk("t3_rel_valid", 32'(bus.out_valid), 32'd0);
        chk("t3_rel_ready", 32'(bus.in_ready),  32'd1);
        chk("t3_keep_P",    32'(bus.out_P),     32'd63);

        // 4: new operands offered during RUN must be ignored
        bus.in_A = 4'd5; bus.in_B = 4'd6; bus.in_valid = 1'b1;
        step();
        lat = 1;
        bus.in_valid = 1'b0;
        step(); lat++;
        bus.in_A = 4'd3; bus.in_B = 4'd3; bus.in_valid = 1'b1;
        chk("t4_busy", 32'(bus.in_ready), 32'd0);
        step(); lat++;
        step(); lat++;
        bus.in_valid = 1'b0;
        while (!bus.out_valid && lat < 40) begin
            step();
            lat++;
        end
        chk("t4_lat",  32'(lat),         32'd5);
        chk("t4_prod", 32'(bus.out_P),   32'd30);
        step();
        chk("t4_idle", 32'(bus.in_ready), 32'd1);

        // 5: reset two cycles into RUN abandons the operation
        bus.in_A = 4'd13; bus.in_B = 4'd11; bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t5_valid", 32'(bus.out_valid), 32'd0);
        chk("t5_P",     32'(bus.out_P),     32'd0);
        chk("t5_ready", 32'(bus.in_ready),  32'd1);
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            seen |= bus.out_valid;
        end
        chk("t5_no_pulse", 32'(seen), 32'd0);
        run_op(4'd6, 4'd7, 1'b1, lat, prod);
        chk("t5_lat",  32'(lat),  32'd5);
        chk("t5_prod", 32'(prod), 32'd42);
        step();

        // reset while a product waits in DONE
        run_op(4'd2, 4'd3, 1'b0, lat, prod);
        chk("t5b_prod", 32'(prod), 32'd6);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t5b_valid", 32'(bus.out_valid), 32'd0);
        chk("t5b_P",     32'(bus.out_P),     32'd0);
        chk("t5b_ready", 32'(bus.in_ready),  32'd1);

        // 6: zero operands
        run_op(4'd0, 4'd9, 1'b1, lat, prod);
        chk("t6_lat",  32'(lat),  32'(ZLAT));
        chk("t6_prod", 32'(prod), 32'd0);
        step();
        run_op(4'd11, 4'd0, 1'b1, lat, prod);
        chk("t6b_lat",  32'(lat),  32'(ZLAT));
        chk("t6b_prod", 32'(prod), 32'd0);
        step();

        // exhaustive sweep with random downstream backpressure
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                int n;
                bus.in_A = 4'(a); bus.in_B = 4'(b); bus.in_valid = 1'b1;
                lat = 0;
                while (lat < 40) begin
                    bus.out_ready = 1'($urandom_range(0, 1));
                    step();
                    lat++;
                    if (lat == 1) bus.in_valid = 1'b0;
                    if (bus.out_valid) break;
                end
                bus.in_valid = 1'b0;
                chk("sw_lat",  32'(lat), (a == 0 || b == 0) ? 32'(ZLAT) : 32'd5);
                chk("sw_prod", 32'(bus.out_P), 32'(a * b));
                n = 0;
                while (!bus.in_ready && n < 20) begin
                    bus.out_ready = (n > 4) ? 1'b1 : 1'($urandom_range(0, 1));
                    step();
                    n++;
                    if (bus.out_valid) chk("sw_hold", 32'(bus.out_P), 32'(a * b));
                end
                chk("sw_release", 32'(bus.in_ready), 32'd1);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
